grad_update_unit: RTL and testbench
===================================

GRAD_UPDATE_UNIT -- requirements
Module: grad_update_unit

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel update lanes (1..16).
REQ-002 SHALL have parameter WIDTH, default 16, fixed-point word width.
REQ-003 SHALL have parameter FRAC, default 8, fractional bits (Q(WIDTH-FRAC).FRAC, two's complement).
REQ-004 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port lr_in, input, WIDTH, learning rate, shared by all lanes.
REQ-007 SHALL have port beta_in, input, WIDTH, momentum factor; used only per REQ-027.
REQ-008 SHALL have port value_old_in, input, LANES*WIDTH, current parameter per lane; lane i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port grad_in, input, LANES*WIDTH, gradient per lane; same packing.
REQ-010 SHALL have port bias_mode_in, input, 1: 1 = bias accumulate mode, 0 = weight mode.
REQ-011 SHALL have port first_in, input, 1, first beat of a bias batch.
REQ-012 SHALL have port vel_clr_in, input, 1, clear all velocity registers.
REQ-013 SHALL have port in_valid, input, 1, and port in_ready, output, 1, input handshake.
REQ-014 SHALL have port value_out, output, LANES*WIDTH, updated parameters.
REQ-015 SHALL have port out_valid, output, 1, and port out_ready, input, 1, output handshake.

Function
REQ-016 SHALL transfer an input beat when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-017 SHALL be a 2-stage pipeline: S1 registers step = sat((grad*lr) >>> FRAC); S2 registers result = sat(minuend - step).
REQ-018 SHALL give 2-cycle latency from accepted input to out_valid with no backpressure, at one beat per cycle throughput.
REQ-019 SHALL compute products at 2*WIDTH bits, arithmetic right shift with truncation toward negative infinity, and saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 SHALL saturate subtraction to the same range, never wrapping.
REQ-021 SHALL use value_old_in as minuend in weight mode, and in bias mode when first_in=1.
REQ-022 SHALL use that lane's previous S2 result as minuend in bias mode with first_in=0, so successive bias beats accumulate.
REQ-023 SHALL carry bias_mode and first with the beat through S1; the minuend select in REQ-021/REQ-022 SHALL be made in S2, so back-to-back bias beats need no stall.
REQ-024 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready; a full pipeline with out_ready=0 SHALL hold all registers and value_out stable.
REQ-025 SHALL clear out_valid after a transfer when no new S2 beat is loaded; value_out SHALL hold its last value.

Reset
REQ-026 SHALL, on rst, clear s1_valid, out_valid, value_out, step registers, velocity registers and accumulator registers to 0; in_ready SHALL be 1 after reset; reset mid-burst SHALL discard in-flight beats.

Configuration
REQ-027 SHALL, with GDU_MOMENTUM_EN defined, keep per-lane velocity v = sat(((beta*v) >>> FRAC) + grad), updated on each accepted beat, and use v in place of grad in REQ-017.
REQ-028 SHALL clear v to 0 when vel_clr_in=1 at an accepted beat, before that beat's velocity update.
REQ-029 SHALL, without GDU_MOMENTUM_EN, omit velocity state entirely and ignore beta_in and vel_clr_in.

Structure
REQ-030 SHALL place the saturation bounds, the FRAC/WIDTH defaults and the lane-slice helper in shared package gdu_pkg.
REQ-031 SHALL instantiate one sub-module gdu_lane per lane, holding the lane's multiply, saturate, subtract and optional velocity.

Verification
REQ-032 SHALL check weight mode, LANES=4, lr=0x0080, grad=0x0200, value=0x0300 on all lanes -> value_out lanes = 0x0200 two cycles later.
REQ-033 SHALL check saturation: value=0x8100, grad=0x7FFF, lr=0x0100 -> lane result 0x8000; negated grad on value=0x7F00 -> 0x7FFF.
REQ-034 SHALL check bias mode: beats (first=1, value=0x0400, grad=0x0100), (first=0, grad=0x0100), lr=0x0100, back-to-back -> outputs 0x0300 then 0x0200.
REQ-035 SHALL check backpressure: out_ready=0 for 5 cycles with 3 beats offered -> exactly 2 accepted, in_ready=0, value_out stable; release -> beats emerge in order with no loss or duplication.
REQ-036 SHALL check, with GDU_MOMENTUM_EN, beta=0x0080, lr=0x0100, grad=0x0100 twice, value=0 each beat -> outputs 0xFF00 then 0xFE80; vel_clr_in on the third beat -> 0xFF00.
REQ-037 SHALL check that asserting rst with 2 beats in flight gives out_valid=0, value_out=0, and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/gdu_pkg.sv
// rtl/gdu_pkg.sv - shared defaults, saturation bounds and lane slicing for grad_update_unit
package gdu_pkg;

  localparam int GDU_LANES_DEF = 4;
  localparam int GDU_WIDTH_DEF = 16;
  localparam int GDU_FRAC_DEF  = 8;

  // Wide enough to hold a full WIDTH x WIDTH product for WIDTH up to 32.
  localparam int GDU_CALC_W    = 64;

  typedef logic signed [GDU_CALC_W-1:0] calc_t;

  function automatic calc_t sat_max(input int width);
    return (calc_t'(64'sd1) <<< (width - 1)) - calc_t'(64'sd1);
  endfunction

  function automatic calc_t sat_min(input int width);
    return -(calc_t'(64'sd1) <<< (width - 1));
  endfunction

  function automatic calc_t sat_clip(input calc_t x, input int width);
    calc_t hi;
    calc_t lo;
    hi = sat_max(width);
    lo = sat_min(width);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Sign-extends the low 'width' bits of x to the full calculation width.
  function automatic calc_t sext(input calc_t x, input int width);
    return (x <<< (GDU_CALC_W - width)) >>> (GDU_CALC_W - width);
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/gdu_lane.sv
// rtl/gdu_lane.sv - one update lane: scaled step, saturating subtract, optional velocity (GDU_MOMENTUM_EN)
module gdu_lane
  import gdu_pkg::*;
#(
  parameter int WIDTH = GDU_WIDTH_DEF,
  parameter int FRAC  = GDU_FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_accept,
  input  logic             i_load_s2,
  input  logic             i_use_acc,
`ifdef GDU_MOMENTUM_EN
  input  logic             i_vel_clr,
  input  logic [WIDTH-1:0] i_beta,
`endif
  input  logic [WIDTH-1:0] i_lr,
  input  logic [WIDTH-1:0] i_grad,
  input  logic [WIDTH-1:0] i_value_old,
  output logic [WIDTH-1:0] o_value
);

  calc_t            w_grad;
  calc_t            w_lr;
  calc_t            w_grad_eff;
  calc_t            w_minuend;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_result;

  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] r_old;
  logic [WIDTH-1:0] r_value;

  assign w_grad = sext(calc_t'(i_grad), WIDTH);
  assign w_lr   = sext(calc_t'(i_lr), WIDTH);

`ifdef GDU_MOMENTUM_EN
  calc_t            w_beta;
  calc_t            w_vel_base;
  logic [WIDTH-1:0] w_vel_new;
  logic [WIDTH-1:0] r_vel;

  // A clear request zeroes the history before this beat's own gradient is folded in.
  assign w_beta     = sext(calc_t'(i_beta), WIDTH);
  assign w_vel_base = i_vel_clr ? '0 : sext(calc_t'(r_vel), WIDTH);
  assign w_vel_new  = WIDTH'(sat_clip(((w_beta * w_vel_base) >>> FRAC) + w_grad, WIDTH));
  assign w_grad_eff = sext(calc_t'(w_vel_new), WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vel <= '0;
    end else if (i_accept) begin
      r_vel <= w_vel_new;
    end
  end
`else
  assign w_grad_eff = w_grad;
`endif

  assign w_step    = WIDTH'(sat_clip((w_grad_eff * w_lr) >>> FRAC, WIDTH));
  assign w_minuend = i_use_acc ? sext(calc_t'(r_value), WIDTH) : sext(calc_t'(r_old), WIDTH);
  assign w_result  = WIDTH'(sat_clip(w_minuend - sext(calc_t'(r_step), WIDTH), WIDTH));

  // r_value doubles as the bias accumulator, so a held output is also the running sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step  <= '0;
      r_old   <= '0;
      r_value <= '0;
    end else begin
      if (i_accept) begin
        r_step <= w_step;
        r_old  <= i_value_old;
      end
      if (i_load_s2) begin
        r_value <= w_result;
      end
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/grad_update_unit.sv
// rtl/grad_update_unit.sv - two-stage multi-lane SGD update with bias accumulate; momentum under GDU_MOMENTUM_EN
module grad_update_unit
  import gdu_pkg::*;
#(
  parameter int LANES = GDU_LANES_DEF,
  parameter int WIDTH = GDU_WIDTH_DEF,
  parameter int FRAC  = GDU_FRAC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       lr_in,
  input  logic [WIDTH-1:0]       beta_in,
  input  logic [LANES*WIDTH-1:0] value_old_in,
  input  logic [LANES*WIDTH-1:0] grad_in,
  input  logic                   bias_mode_in,
  input  logic                   first_in,
  input  logic                   vel_clr_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] value_out,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic r_s1_valid;
  logic r_s1_bias;
  logic r_s1_first;
  logic r_out_valid;

  logic w_s2_en;
  logic w_accept;
  logic w_load_s2;
  logic w_use_acc;

  assign w_s2_en   = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_load_s2 = w_s2_en && r_s1_valid;
  // Minuend choice is resolved in S2 so a following bias beat sees the fresh accumulator.
  assign w_use_acc = r_s1_bias && !r_s1_first;
  assign out_valid = r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_bias   <= 1'b0;
      r_s1_first  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_bias  <= bias_mode_in;
          r_s1_first <= first_in;
        end
      end
      if (w_s2_en) begin
        r_out_valid <= r_s1_valid;
      end
    end
  end

`ifndef GDU_MOMENTUM_EN
  logic w_unused_cfg;
  assign w_unused_cfg = ^{beta_in, vel_clr_in};
`endif

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      localparam int LO = lane_lo(g, WIDTH);
      gdu_lane #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
      ) u_lane (
        .clk        (clk),
        .rst        (rst),
        .i_accept   (w_accept),
        .i_load_s2  (w_load_s2),
        .i_use_acc  (w_use_acc),
`ifdef GDU_MOMENTUM_EN
        .i_vel_clr  (vel_clr_in),
        .i_beta     (beta_in),
`endif
        .i_lr       (lr_in),
        .i_grad     (grad_in[LO +: WIDTH]),
        .i_value_old(value_old_in[LO +: WIDTH]),
        .o_value    (value_out[LO +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_grad_update_unit.sv
// tb/tb_grad_update_unit.sv - self-checking bench for grad_update_unit (both GDU_MOMENTUM_EN builds)
module tb_grad_update_unit;

  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam longint SCALE = 256;
  localparam longint MAXV  = 32767;
  localparam longint MINV  = -32768;

  logic                   clk;
  logic                   rst;
  logic [WIDTH-1:0]       lr_in;
  logic [WIDTH-1:0]       beta_in;
  logic [LANES*WIDTH-1:0] value_old_in;
  logic [LANES*WIDTH-1:0] grad_in;
  logic                   bias_mode_in;
  logic                   first_in;
  logic                   vel_clr_in;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] value_out;
  logic                   out_valid;
  logic                   out_ready;

  grad_update_unit #(.LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .lr_in(lr_in), .beta_in(beta_in),
    .value_old_in(value_old_in), .grad_in(grad_in),
    .bias_mode_in(bias_mode_in), .first_in(first_in), .vel_clr_in(vel_clr_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .value_out(value_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit sb_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LANES*WIDTH-1:0] rep(input logic [WIDTH-1:0] v);
    return {LANES{v}};
  endfunction

  // Reference model: plain integer arithmetic on the update rules.
  function automatic longint sx(input logic [WIDTH-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clip(input longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    longint p;
    longint q;
    p = a * b;
    q = p / SCALE;
    if (p < 0 && q * SCALE != p) q = q - 1;
    return q;
  endfunction

  longint m_last[LANES];
`ifdef GDU_MOMENTUM_EN
  longint m_vel[LANES];
`endif
  logic [LANES*WIDTH-1:0] exp_q[$];

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_last[l] = 0;
`ifdef GDU_MOMENTUM_EN
      m_vel[l] = 0;
`endif
    end
    exp_q.delete();
  endtask

  task automatic model_accept();
    logic [LANES*WIDTH-1:0] res;
    res = '0;
    for (int l = 0; l < LANES; l++) begin
      longint gv;
      longint st;
      longint mn;
      longint r;
      gv = sx(grad_in[l*WIDTH +: WIDTH]);
`ifdef GDU_MOMENTUM_EN
      if (vel_clr_in) m_vel[l] = 0;
      m_vel[l] = clip(fmul(sx(beta_in), m_vel[l]) + gv);
      gv = m_vel[l];
`endif
      st = clip(fmul(gv, sx(lr_in)));
      mn = (bias_mode_in && !first_in) ? m_last[l] : sx(value_old_in[l*WIDTH +: WIDTH]);
      r = clip(mn - st);
      m_last[l] = r;
      res[l*WIDTH +: WIDTH] = WIDTH'(r);
    end
    exp_q.push_back(res);
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          check("rand_out", value_out, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) model_accept();
    end
  end

  typedef struct {
    logic [WIDTH-1:0] lr;
    logic [WIDTH-1:0] grad;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic set_beat(input logic [WIDTH-1:0] lr, input logic [WIDTH-1:0] grad,
                          input logic [WIDTH-1:0] value, input logic bias,
                          input logic first, input logic clr);
    lr_in        = lr;
    grad_in      = rep(grad);
    value_old_in = rep(value);
    bias_mode_in = bias;
    first_in     = first;
    vel_clr_in   = clr;
  endtask

  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  logic [LANES*WIDTH-1:0] bp_vals[3];
  logic [LANES*WIDTH-1:0] got[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp_idx;
    int accepted;
    int n_out;
    logic [LANES*WIDTH-1:0] snap;
    bit take;

    rst = 1'b1;
    set_beat(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    beta_in   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_value_out", value_out, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    vecs[0] = '{16'h0080, 16'h0200, 16'h0300, 16'h0200};
    vecs[1] = '{16'h0100, 16'h7FFF, 16'h8100, 16'h8000};
    vecs[2] = '{16'h0100, 16'h8001, 16'h7F00, 16'h7FFF};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h8001};
    vecs[4] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0001};
    vecs[5] = '{16'h0001, 16'h00FF, 16'h1234, 16'h1234};
    vecs[6] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      set_beat(vecs[i].lr, vecs[i].grad, vecs[i].value, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b1;
      wait_accept($sformatf("vec%0d_accept", i));
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), {out_valid, value_out}, {1'b1, rep(vecs[i].exp)});
      @(posedge clk);
      #1;
    end

    // Back-to-back bias beats: second one must subtract from the first's result.
    set_beat(16'h0100, 16'h0100, 16'h0400, 1'b1, 1'b1, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    check("bias_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 set_beat(16'h0100, 16'h0100, 16'h7777, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bias_beat0", {out_valid, value_out}, {1'b1, rep(16'h0300)});
    @(posedge clk);
    @(negedge clk);
    check("bias_beat1", {out_valid, value_out}, {1'b1, rep(16'h0200)});
    @(posedge clk);
    #1;

    // Momentum sequence; without the feature beta and vel_clr must have no effect.
    beta_in = 16'h0080;
    set_beat(16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 vel_clr_in = 1'b0;
    @(posedge clk);
    #1 vel_clr_in = 1'b1;
    @(negedge clk);
    check("mom_beat0", {out_valid, value_out}, {1'b1, rep(16'hFF00)});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
`ifdef GDU_MOMENTUM_EN
    check("mom_beat1", {out_valid, value_out}, {1'b1, rep(16'hFE80)});
`else
    check("nomom_beat1", {out_valid, value_out}, {1'b1, rep(16'hFF00)});
`endif
    @(posedge clk);
    @(negedge clk);
    check("mom_beat2", {out_valid, value_out}, {1'b1, rep(16'hFF00)});
    @(posedge clk);
    #1 beta_in = '0;

    // Backpressure: three beats offered against a stalled output.
    bp_vals[0] = rep(16'h0011);
    bp_vals[1] = rep(16'h0022);
    bp_vals[2] = rep(16'h0033);
    out_ready = 1'b0;
    bp_idx = 0;
    accepted = 0;
    snap = '0;
    set_beat(16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    value_old_in = bp_vals[0];
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      if (take) accepted++;
      if (c == 2) snap = value_out;
      @(posedge clk);
      #1;
      if (take) begin
        bp_idx++;
        if (bp_idx < 3) value_old_in = bp_vals[bp_idx];
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("bp_accepted", 64'(accepted), 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_stable", value_out, snap);
    check("bp_head", {out_valid, value_out}, {1'b1, bp_vals[0]});
    @(posedge clk);
    #1 out_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (n_out < 8) got[n_out] = value_out;
        n_out++;
      end
      take = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (take) begin
        bp_idx++;
        in_valid = 1'b0;
      end
    end
    check("bp_out_count", 64'(n_out), 64'd3);
    for (int k = 0; k < 3; k++) check($sformatf("bp_out%0d", k), got[k], bp_vals[k]);

    // Reset with two beats in flight.
    set_beat(16'h0100, 16'h0100, 16'h0500, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_value_out", value_out, 64'd0);
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    take = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid) take = 1'b1;
    end
    check("rst_mid_no_ghost", {63'd0, take}, 64'd0);

    // Randomized traffic against the reference model.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    sb_en = 1'b1;
    for (int c = 0; c < 500; c++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 9) < 7);
      bias_mode_in = $urandom_range(0, 1) == 1;
      first_in     = $urandom_range(0, 3) == 0;
      vel_clr_in   = $urandom_range(0, 9) == 0;
      beta_in      = WIDTH'($urandom_range(0, 255));
      lr_in        = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 511));
      grad_in      = {$urandom, $urandom};
      value_old_in = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 sb_en = 1'b0;
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
